arb_conv_32b_8b: RTL and testbench

Round-robin arbiter and sequencer that shares one 32b→8b serialization path among up to 8 requesters. Each requester offers 32-bit words with a valid/ready handshake; the block grants one word at a time and emits it as four bytes, MSB first, on `data_out`/`valid_out`. It runs entirely in the `clk_4f` domain, so a requester can sustain one word per `clk` period (four `clk_4f` cycles) with no idle bytes between words.

---
 rtl/arb_conv_32b_8b.sv | 100 ++++++++++
 tb/tb_arb_conv_32b_8b.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_conv_32b_8b.sv
// rtl/arb_conv_32b_8b.sv - round-robin arbiter feeding one 32b-to-8b serializer, MSB byte first
module arb_conv_32b_8b #(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   valid_out,
  output logic [7:0]             data_out,
  output logic [2:0]             grant_id,
  output logic                   busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [31:0] shreg;
  logic [1:0]  cnt;
  logic [2:0]  last;

  logic [7:0]  valid8;
  logic [31:0] words [8];
  logic        accept_open;
  logic        found;
  logic        take;
  logic [2:0]  win;
  logic [3:0]  cand;
  logic [31:0] win_word;

  // Pad requester vectors to 8 entries so a 3-bit index is always in range.
  always_comb begin
    valid8 = '0;
    valid8[NUM_REQ-1:0] = req_valid;
    for (int i = 0; i < 8; i++) words[i] = '0;
    for (int i = 0; i < NUM_REQ; i++) words[i] = req_data[32*i +: 32];
  end

  assign accept_open = !reset && (state == IDLE || cnt == 2'd3);

  // Search last+1, last+2, ... modulo NUM_REQ; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && valid8[cand[2:0]]) begin
        found = 1'b1;
        win   = cand[2:0];
      end
    end
  end

  assign take     = accept_open && found;
  assign win_word = words[win];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) req_ready[i] = take && (win == 3'(i));
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= IDLE;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      data_out  <= IDLE_BYTE;
      grant_id  <= '0;
      cnt       <= '0;
      shreg     <= '0;
      last      <= 3'(NUM_REQ - 1);
    end else if (take) begin
      state     <= SEND;
      valid_out <= 1'b1;
      busy      <= 1'b1;
      data_out  <= win_word[31:24];
      shreg     <= {win_word[23:0], 8'h00};
      grant_id  <= win;
      cnt       <= '0;
      last      <= win;
    end else if (state == SEND) begin
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        // Last byte shown and nobody waiting: drop back to idle.
        state     <= IDLE;
        valid_out <= 1'b0;
        busy      <= 1'b0;
        data_out  <= IDLE_BYTE;
      end else begin
        data_out <= shreg[31:24];
        shreg    <= {shreg[23:0], 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_arb_conv_32b_8b.sv
// tb/tb_arb_conv_32b_8b.sv - self-checking bench for arb_conv_32b_8b
module tb_arb_conv_32b_8b;

  logic         clk_4f = 1'b0;
  logic         reset  = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data  = '0;
  logic [3:0]   req_ready;
  logic         valid_out;
  logic [7:0]   data_out;
  logic [2:0]   grant_id;
  logic         busy;

  int total = 0;
  int bad   = 0;

  arb_conv_32b_8b #(.NUM_REQ(4), .IDLE_BYTE(8'hBC)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'hF;
    req_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    total++; if (data_out !== 8'hBC) begin bad++; $display("FAIL reset_data got=%h exp=bc", data_out); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wq[$];
    logic        vo[12];
    logic [7:0]  dout[12];
    logic [3:0]  rdy[12];
    wq = '{32'hFFFFFFFF, 32'hDDDDDDDD};
    for (int c = 0; c < 12; c++) begin
      vo[c] = valid_out;
      dout[c] = data_out;
      if (wq.size() > 0) begin req_valid = 4'b0001; req_data[31:0] = wq[0]; end
      else req_valid = '0;
      #1;
      rdy[c] = req_ready;
      if (req_ready[0]) void'(wq.pop_front());
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      total++;
      if (rdy[c] !== ((c == 0 || c == 4) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL b2b_ready cyc=%0d got=%b", c, rdy[c]);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (vo[c] !== 1'b1 || dout[c] !== ((c <= 4) ? 8'hFF : 8'hDD)) begin
        bad++; $display("FAIL b2b_byte cyc=%0d got=%b/%h exp=1/%h", c, vo[c], dout[c], (c <= 4) ? 8'hFF : 8'hDD);
      end
    end
    total++;
    if (vo[9] !== 1'b0 || dout[9] !== 8'hBC) begin
      bad++; $display("FAIL b2b_tail got=%b/%h exp=0/bc", vo[9], dout[9]);
    end
  endtask

  task automatic test_byte_order();
    logic        vo[7];
    logic [7:0]  dout[7];
    logic [2:0]  gid[7];
    logic [3:0]  rdy[7];
    logic [31:0] w;
    w = 32'h12345678;
    for (int c = 0; c < 7; c++) begin
      vo[c] = valid_out; dout[c] = data_out; gid[c] = grant_id;
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      req_data[95:64] = w;
      #1;
      rdy[c] = req_ready;
      tick();
    end
    for (int c = 0; c < 7; c++) begin
      total++;
      if (rdy[c] !== ((c == 0) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL order_ready cyc=%0d got=%b", c, rdy[c]); end
    end
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (vo[c] !== 1'b1 || dout[c] !== byte_of(w, c-1) || gid[c] !== 3'd2) begin
        bad++; $display("FAIL order_byte cyc=%0d got=%b/%h/%0d exp=1/%h/2", c, vo[c], dout[c], gid[c], byte_of(w, c-1));
      end
    end
    total++;
    if (vo[5] !== 1'b0 || dout[5] !== 8'hBC) begin bad++; $display("FAIL order_tail got=%b/%h exp=0/bc", vo[5], dout[5]); end
  endtask

  task automatic test_round_robin();
    logic [31:0] w[4];
    logic        vo[26];
    logic [7:0]  dout[26];
    logic [2:0]  gid[26];
    logic [3:0]  rdy[26];
    int          grants;
    w = '{32'h00000003, 32'h11111111, 32'h22222222, 32'h33333333};
    do_reset();
    req_data = {w[3], w[2], w[1], w[0]};
    grants = 0;
    for (int c = 0; c < 26; c++) begin
      vo[c] = valid_out; dout[c] = data_out; gid[c] = grant_id;
      req_valid = (grants < 6) ? 4'hF : 4'h0;
      #1;
      rdy[c] = req_ready;
      if (req_ready != 4'b0) grants++;
      tick();
    end
    for (int c = 0; c < 26; c++) begin
      logic [3:0] exp_r;
      exp_r = (c % 4 == 0 && c <= 20) ? 4'(1 << ((c / 4) % 4)) : 4'b0;
      total++;
      if (rdy[c] !== exp_r) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, rdy[c], exp_r); end
    end
    for (int c = 1; c <= 24; c++) begin
      int id;
      id = ((c - 1) / 4) % 4;
      total++;
      if (vo[c] !== 1'b1 || gid[c] !== 3'(id) || dout[c] !== byte_of(w[id], (c-1) % 4)) begin
        bad++; $display("FAIL rr_byte cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", c, vo[c], gid[c], dout[c], id, byte_of(w[id], (c-1) % 4));
      end
    end
    total++;
    if (vo[25] !== 1'b0) begin bad++; $display("FAIL rr_tail got=%b exp=0", vo[25]); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    req_data[127:96] = 32'hAABBCCDD;
    req_data[63:32]  = 32'h01020304;
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL mid_grant3 got=%b exp=1000", req_ready); end
    tick();
    total++; if (valid_out !== 1'b1 || data_out !== 8'hAA || grant_id !== 3'd3) begin bad++; $display("FAIL mid_aa got=%b/%h/%0d", valid_out, data_out, grant_id); end
    req_valid = 4'b1010;
    #1;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL mid_busy_ready got=%b exp=0000", req_ready); end
    tick();
    total++; if (data_out !== 8'hBB) begin bad++; $display("FAIL mid_bb got=%h exp=bb", data_out); end
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    tick();
    total++; if (valid_out !== 1'b0 || data_out !== 8'hBC || busy !== 1'b0) begin bad++; $display("FAIL mid_flush got=%b/%h/%b exp=0/bc/0", valid_out, data_out, busy); end
    reset = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_regrant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (valid_out !== 1'b1 || grant_id !== 3'd1 || data_out !== byte_of(32'h01020304, k)) begin
        bad++; $display("FAIL mid_r1 k=%0d got=%b/%0d/%h exp=1/1/%h", k, valid_out, grant_id, data_out, byte_of(32'h01020304, k));
      end
      tick();
    end
    tick();
  endtask

  task automatic test_gap();
    logic [31:0] w1, w0;
    w1 = 32'hCAFEF00D;
    w0 = 32'h0BADBEEF;
    req_data[63:32] = w1;
    req_data[31:0]  = w0;
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL gap_grant1 got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (valid_out !== 1'b1 || grant_id !== 3'd1 || data_out !== byte_of(w1, k)) begin
        bad++; $display("FAIL gap_byte k=%0d got=%b/%0d/%h exp=1/1/%h", k, valid_out, grant_id, data_out, byte_of(w1, k));
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (valid_out !== 1'b0 || data_out !== 8'hBC || req_ready !== 4'b0) begin
        bad++; $display("FAIL gap_idle k=%0d got=%b/%h/%b exp=0/bc/0000", k, valid_out, data_out, req_ready);
      end
      tick();
    end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL gap_idle3 got=%b exp=0", valid_out); end
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL gap_grant0 got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (valid_out !== 1'b1 || grant_id !== 3'd0 || data_out !== 8'h0B) begin bad++; $display("FAIL gap_first0 got=%b/%0d/%h exp=1/0/0b", valid_out, grant_id, data_out); end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_random();
    logic        pend[4];
    logic [31:0] wd[4];
    logic        m_cv;
    logic [7:0]  m_byte;
    int          m_id, m_last, win;
    logic [7:0]  mq[$];
    logic        rst;
    logic [3:0]  exp_r;
    do_reset();
    m_cv = 1'b0; m_byte = 8'h00; m_id = 0; m_last = 3; mq.delete();
    for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; wd[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      total++;
      if (valid_out !== m_cv || busy !== m_cv) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", c, valid_out, busy, m_cv); end
      total++;
      if (m_cv) begin
        if (data_out !== m_byte || grant_id !== 3'(m_id)) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h/%0d exp=%h/%0d", c, data_out, grant_id, m_byte, m_id); end
      end else if (data_out !== 8'hBC) begin
        bad++; $display("FAIL rnd_idle cyc=%0d got=%h exp=bc", c, data_out);
      end
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) != 0) begin pend[i] = 1'b1; wd[i] = $urandom; end
        end else if ($urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end
        req_valid[i] = pend[i];
        req_data[32*i +: 32] = wd[i];
      end
      reset = rst;
      win = -1;
      if (!rst && (!m_cv || mq.size() == 0)) begin
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_last + k) % 4;
          if (win < 0 && pend[i]) win = i;
        end
      end
      exp_r = (win >= 0) ? 4'(1 << win) : 4'b0;
      #1;
      total++;
      if (req_ready !== exp_r) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_r); end
      if (rst) begin
        m_cv = 1'b0; mq.delete(); m_last = 3;
      end else if (win >= 0) begin
        m_cv = 1'b1; m_byte = wd[win][31:24]; m_id = win; m_last = win;
        mq = '{wd[win][23:16], wd[win][15:8], wd[win][7:0]};
        pend[win] = 1'b0;
      end else if (m_cv) begin
        if (mq.size() > 0) m_byte = mq.pop_front();
        else m_cv = 1'b0;
      end
      tick();
    end
    reset = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_order();
    test_round_robin();
    test_reset_midword();
    test_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
